// File: rtl/uart_rx_axis_if.sv
// AXI-Stream beat bundle between the UART receiver and the fabric.
// tuser flags a word that failed its parity check.
interface uart_rx_axis_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/uart_rx_axis.sv
// Oversampling UART receiver with majority vote feeding an AXIS FIFO.
// Define UART_RX_BREAK_DETECT_EN to add the break_det output.
module uart_rx_axis #(
  parameter int    CLK_FREQ   = 50_000_000,
  parameter int    BAUD       = 115200,
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "even",
  parameter int    STOP_BITS  = 1,
  parameter int    OVERSAMPLE = 16,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  uart_rx_axis_if.master              m_axis,
  output logic                        parity_error,
  output logic                        frame_error,
  output logic                        overrun_error,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                        break_det,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DVW     = $clog2(DIV + 1);
  localparam int SCW     = $clog2(OVERSAMPLE);
  localparam int BCW     = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam bit PAR_EN  = (PARITY != "none");
  localparam bit PAR_ODD = (PARITY == "odd");

  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
  localparam logic [SCW-1:0] SC_LO    = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_MID   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_DEC   = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
  } state_t;

  state_t                 r_state, w_nxt;
  logic                   r_rx_s1, r_rx_s2;
  logic [DVW-1:0]         r_div;
  logic [SCW-1:0]         r_scnt;
  logic [BCW-1:0]         r_bcnt;
  logic                   r_s0, r_s1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit;
  logic                   r_stop;
  logic [DATA_BITS:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;

  logic w_rx, w_tick, w_dec, w_end, w_maj;
  logic w_start, w_push, w_ferr, w_stop_last;
  logic w_pfail, w_full, w_pop, w_wr;

  assign w_rx   = r_rx_s2;
  assign w_tick = (r_div == DIV_LAST);
  assign w_dec  = w_tick && (r_scnt == SC_DEC);
  assign w_end  = w_tick && (r_scnt == SC_LAST);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_stop_last = (r_stop == 1'(STOP_BITS - 1));
  assign w_pfail = PAR_EN & ((^r_shift) ^ r_par_bit ^ PAR_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_push  = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_nxt   = S_START;
          w_start = 1'b1;
        end
      end
      S_START: begin
        if (w_dec && w_maj) w_nxt = S_IDLE;
        else if (w_end)     w_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_end && r_bcnt == BC_LAST)
          w_nxt = PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_end) w_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_dec && !w_maj) begin
          w_nxt  = S_WAIT;
          w_ferr = 1'b1;
        end else if (w_dec && w_stop_last) begin
          w_nxt  = S_IDLE;
          w_push = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_rx) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Divider free-runs; sample counter only moves while inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_stop    <= 1'b0;
    end else if (w_start) begin
      r_div     <= '0;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_par_bit <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick && r_state != S_IDLE && r_state != S_WAIT) begin
        r_scnt <= (r_scnt == SC_LAST) ? '0 : r_scnt + 1'b1;
        if (r_scnt == SC_LO)  r_s0 <= w_rx;
        if (r_scnt == SC_MID) r_s1 <= w_rx;
        if (w_dec && r_state == S_DATA)
          r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        if (w_dec && r_state == S_PARITY)
          r_par_bit <= w_maj;
        if (w_end && r_state == S_DATA) r_bcnt <= r_bcnt + 1'b1;
        if (w_end && r_state == S_STOP) r_stop <= 1'b1;
      end
    end
  end

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = m_axis.tvalid && m_axis.tready;
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= {w_pfail, r_shift};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_axis.tdata  = r_mem[r_rptr][DATA_BITS-1:0];
  assign m_axis.tuser  = r_mem[r_rptr][DATA_BITS];
  assign m_axis.tvalid = (r_count != '0);
  assign fifo_count    = r_count;
  assign parity_error  = w_wr && w_pfail;
  assign overrun_error = w_push && w_full && !w_pop;

`ifdef UART_RX_BREAK_DETECT_EN
  logic w_brk;
  assign w_brk = (r_shift == '0) && !r_par_bit && !r_stop;
  assign break_det   = w_ferr && w_brk;
  assign frame_error = w_ferr && !w_brk;
`else
  assign frame_error = w_ferr;
`endif

endmodule
